// File: rtl/div_unit_if.sv
// div_unit_if: start/cancel request and result bundle between
// the execute stage and the iterative divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             W_start;
  logic             W_signed;
  logic [WIDTH-1:0] W_a;
  logic [WIDTH-1:0] W_b;
  logic             W_cancel;
  logic             R_busy;
  logic             R_done;
  logic [WIDTH-1:0] R_quot;
  logic [WIDTH-1:0] R_rem;
  logic             R_div_zero;

  modport master (
    output W_start, W_signed, W_a, W_b, W_cancel,
    input  R_busy, R_done, R_quot, R_rem, R_div_zero
  );

  modport slave (
    input  W_start, W_signed, W_a, W_b, W_cancel,
    output R_busy, R_done, R_quot, R_rem, R_div_zero
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: restoring shift-subtract divider for DIV/DIVU,
// one quotient bit per cycle, quotient to LO, remainder to HI.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       W_clk,
  input  logic       W_rst_n,
  div_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [4:0] LAST   = 5'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_abs_a = (bus.W_signed && bus.W_a[WIDTH-1])
                 ? -bus.W_a : bus.W_a;
  assign w_abs_b = (bus.W_signed && bus.W_b[WIDTH-1])
                 ? -bus.W_b : bus.W_b;

  // Bit WIDTH of the difference is the borrow of the trial subtract.
  assign w_shift = {r_prem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_ge    = ~w_diff[WIDTH];

  // Divide by zero leaves the all-ones quotient unsigned.
  assign w_quot_fix = (r_neg_q && !r_dz) ? -r_dvd : r_dvd;
  assign w_rem_fix  = r_neg_r ? -r_prem : r_prem;

  always_ff @(posedge W_clk or negedge W_rst_n) begin
    if (!W_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_prem     <= '0;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.W_cancel) begin
        r_state <= S_IDLE;
      end else begin
        unique case (1'b1)
          (r_state == S_IDLE): begin
            if (bus.W_start) begin
              r_state <= S_DIV;
              r_cnt   <= '0;
              r_prem  <= '0;
              r_dvd   <= w_abs_a;
              r_dsr   <= w_abs_b;
              r_neg_q <= bus.W_signed
                       & (bus.W_a[WIDTH-1] ^ bus.W_b[WIDTH-1]);
              r_neg_r <= bus.W_signed & bus.W_a[WIDTH-1];
              r_dz    <= (bus.W_b == '0);
            end
          end
          (r_state == S_DIV): begin
            r_prem <= w_ge ? w_diff[WIDTH-1:0]
                           : w_shift[WIDTH-1:0];
            r_dvd  <= {r_dvd[WIDTH-2:0], w_ge};
            if (r_cnt == LAST) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          (r_state == S_FIX): begin
            r_quot     <= w_quot_fix;
            r_rem      <= w_rem_fix;
            r_div_zero <= r_dz;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.R_busy     = (r_state != S_IDLE);
  assign bus.R_done     = r_done;
  assign bus.R_quot     = r_quot;
  assign bus.R_rem      = r_rem;
  assign bus.R_div_zero = r_div_zero;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a plain
// arithmetic reference model and a cycle-accurate monitor.
module tb_div_unit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit u_dut (
    .W_clk   (clk),
    .W_rst_n (rst_n),
    .bus     (bus)
  );

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        scb[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        last_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic s);
    exp_t e;
    int   sa;
    int   sbv;
    sa   = $signed(a);
    sbv  = $signed(b);
    e.t  = 0;
    e.dz = (b == 32'd0);
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = 32'(sa / sbv);
      e.r = 32'(sa % sbv);
    end
    return e;
  endfunction

  // Monitor: busy/done timing, results on done, hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    logic eb;
    logic ed;
    eb = 1'b0;
    ed = 1'b0;
    if (scb.size() > 0) begin
      eb = (cyc >= scb[0].t + 1) && (cyc <= scb[0].t + 33);
      ed = (cyc == scb[0].t + 34);
    end
    check("busy", {31'd0, bus.R_busy}, {31'd0, eb});
    check("done", {31'd0, bus.R_done}, {31'd0, ed});
    if (ed) begin
      e = scb.pop_front();
      check("quot", bus.R_quot, e.q);
      check("rem", bus.R_rem, e.r);
      check("div_zero", {31'd0, bus.R_div_zero}, {31'd0, e.dz});
      last_q  = e.q;
      last_r  = e.r;
      last_dz = e.dz;
    end else begin
      check("hold_quot", bus.R_quot, last_q);
      check("hold_rem", bus.R_rem, last_r);
      check("hold_dz", {31'd0, bus.R_div_zero}, {31'd0, last_dz});
    end
  end

  task automatic issue(logic [31:0] a, logic [31:0] b, logic s);
    exp_t e;
    e = model(a, b, s);
    e.t = cyc;
    bus.W_a      = a;
    bus.W_b      = b;
    bus.W_signed = s;
    bus.W_start  = 1'b1;
    scb.push_back(e);
    @(posedge clk);
    #1;
    bus.W_start  = 1'b0;
    bus.W_a      = $urandom;
    bus.W_b      = $urandom;
    bus.W_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (scb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (scb.size() > 0) begin
      n_fail++;
      $display("FAIL timeout: %0d results pending, expected 0",
               scb.size());
      scb.delete();
    end
    #1;
  endtask

  logic [31:0] d_a [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5,
                           32'hFFFF_FFFB, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'd100};
  logic [31:0] d_b [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0,
                           32'd0, 32'hFFFF_FFFF, 32'd1, 32'd7};
  logic        d_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0,
                           1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] d_q [8] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'h8000_0000, 32'hFFFF_FFFF, 32'd14};
  logic [31:0] d_r [8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5,
                           32'hFFFF_FFFB, 32'd0, 32'd0, 32'd2};
  logic        d_z [8] = '{1'b0, 1'b0, 1'b0, 1'b1,
                           1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    bus.W_start  = 1'b0;
    bus.W_signed = 1'b0;
    bus.W_a      = '0;
    bus.W_b      = '0;
    bus.W_cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      issue(d_a[i], d_b[i], d_s[i]);
      wait_idle();
      check("dir_quot", bus.R_quot, d_q[i]);
      check("dir_rem", bus.R_rem, d_r[i]);
      check("dir_dz", {31'd0, bus.R_div_zero}, {31'd0, d_z[i]});
    end

    // Start during busy is dropped, then cancel at T+10.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.W_a     = 32'd9;
    bus.W_b     = 32'd4;
    bus.W_start = 1'b1;
    @(posedge clk);
    #1;
    bus.W_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.W_cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.W_cancel = 1'b0;
    scb.delete();
    repeat (40) @(posedge clk);
    #1;
    check("cancel_quot", bus.R_quot, 32'd14);
    check("cancel_rem", bus.R_rem, 32'd2);

    bus.W_start  = 1'b1;
    bus.W_cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.W_start  = 1'b0;
    bus.W_cancel = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("start_cancel_busy", {31'd0, bus.R_busy}, 32'd0);

    // Back-to-back: second start in the done cycle.
    issue(32'd1234567, 32'd89, 1'b0);
    repeat (33) @(posedge clk);
    #1;
    issue(32'hFFFF_0000, 32'd77, 1'b1);
    wait_idle();

    // Asynchronous reset mid-operation.
    issue(32'd500, 32'd6, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    scb.delete();
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    #1;
    check("rst_quot", bus.R_quot, 32'd0);
    check("rst_busy", {31'd0, bus.R_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = 32'd0;
      if (k == 1) b = 32'hFFFF_FFFF;
      if (k == 2) a = 32'h8000_0000;
      if (k == 3) b = 32'($urandom_range(1, 15));
      issue(a, b, 1'($urandom_range(0, 1)));
      if (k == 4) begin
        repeat (33) @(posedge clk);
        #1;
        issue($urandom, 32'($urandom_range(1, 1000)),
              1'($urandom_range(0, 1)));
      end
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
